lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store sequencer between the execute stage and the single-port data memory.
- Accepts one memory op per handshake, drives dmem enables, address, byte strobes and data for the programmed read latency, then returns sign/zero-extended load data or store completion.
- Performs alignment and range checks, and holds the pipeline via req_ready while an op is in flight.

Parameters:
- ADDR_W, 15, byte-address width of data memory; dmem word address is ADDR_W-2 bits.
- MEM_LAT, 1, cycles from dmem_rd_en cycle to valid dmem_rd_data (legal 1..7).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  op request
- req_ready  output  1  controller idle, request accepted when req_valid&&req_ready
- req_op  input  4  [1:0] size 00=byte 01=half 10=word 11=illegal; [2] unsigned load; [3] 1=store 0=load
- req_addr  input  32  effective byte address (rs1+imm)
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer takes response
- rsp_rdata  output  32  extended load data; 0 for stores/errors
- rsp_err  output  1  misaligned, out-of-range or illegal size
- busy  output  1  state != IDLE
- dmem_addr  output  ADDR_W-2  word address
- dmem_rd_en  output  1  read strobe, one cycle
- dmem_wr_en  output  1  write strobe, one cycle
- dmem_wr_strb  output  4  byte lane enables
- dmem_wr_data  output  32  lane-replicated write data
- dmem_rd_data  input  32  read data

Behaviour:
- Reset (rst_n low, async): state IDLE, every output 0 except req_ready=1; latched op, address and data cleared.
- States: IDLE, ACCESS, WAIT, RESP. All outputs registered or decoded from state only.
- IDLE: req_ready=1. On accept, latch op/addr/wdata and check:
  - size==11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:ADDR_W]!=0
  - Any hit: go to RESP with rsp_err=1, rsp_rdata=0, no dmem strobe. Otherwise go to ACCESS.
- ACCESS (one cycle): dmem_addr=addr[ADDR_W-1:2].
  - Load: dmem_rd_en=1, load counter with MEM_LAT, go to WAIT.
  - Store: dmem_wr_en=1, go to RESP.
  - Store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - Store data: byte replicated x4; half replicated x2; word as-is.
- WAIT: decrement counter. When counter reaches 1, sample dmem_rd_data, then go to RESP.
  - Shift right by 8*addr[1:0].
  - Sign-extend from bit 7 (byte) or bit 15 (half) unless op[2]=1, then zero-extend.
- RESP: rsp_valid=1 with rdata/err stable until rsp_ready=1, then go to IDLE. No new request is accepted in the same cycle as the response handoff.
- Latency, accept edge = T, MEM_LAT=1:
  - Error: rsp_valid at T+1.
  - Store: wr_en at T+1, rsp_valid at T+2.
  - Load: rd_en at T+1, data sampled at T+2 edge, rsp_valid at T+3.
  - In general, load rsp_valid at T+2+MEM_LAT-1+1.
- rsp_ready high outside RESP: ignored.
- req_valid outside IDLE: ignored, not queued.
- dmem_rd_en and dmem_wr_en are never both high and never high outside ACCESS.
- Reset mid-op: immediate return to IDLE. Any strobe in that cycle deasserts asynchronously. No response is produced.

Optional Feature:
LSU_PERF_CNT_EN
- Defined: adds output ports load_cnt, store_cnt, err_cnt, each 16 bits, reset to 0.
  - load_cnt/store_cnt increment on the ACCESS cycle of a load/store.
  - err_cnt increments on acceptance of an erroring op.
  - All saturate at 16'hFFFF.
- Undefined: ports and logic absent. Core behaviour is identical.

Test Plan:
- Reset, then lw addr 0x0000_0010, MEM_LAT=1, rd_data=0xDEADBEEF -> rd_en at T+1 with dmem_addr=4; rsp_valid at T+3; rsp_rdata=0xDEADBEEF; rsp_err=0.
- lb addr 0x13 with rd_data=0x80AA_5511 -> rsp_rdata=0xFFFF_FF80. Same access as lbu -> 0x0000_0080. lh addr 0x12 -> 0xFFFF_80AA.
- sh addr 0x06, wdata 0x1234_ABCD -> single wr_en cycle, dmem_addr=1, strb=4'b1100, wr_data=0xABCD_ABCD, rsp_valid at T+2.
- lw addr 0x0000_0002, then sw addr 0x0001_0000 (ADDR_W=15) -> rsp_err=1 at T+1 with no dmem strobe. Under LSU_PERF_CNT_EN, err_cnt=2.
- Response backpressure: rsp_ready low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, a concurrent req_valid is not accepted.
- MEM_LAT=3 load, rst_n pulsed low during WAIT -> all outputs 0 except req_ready=1, no rsp_valid, next lw completes normally with rsp_valid at T+5.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the execute stage and a single-port data memory.
// Accepts one op at a time, checks alignment/range/size, strobes dmem for one cycle,
// waits MEM_LAT cycles for loads, then holds the extended result until it is taken.
// Optional build macro: LSU_PERF_CNT_EN adds saturating load/store/error counters.
module lsu_ctrl #(
    parameter int ADDR_W  = 15,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-3:0] dmem_addr,
    output logic              dmem_rd_en,
    output logic              dmem_wr_en,
    output logic [3:0]        dmem_wr_strb,
    output logic [31:0]       dmem_wr_data,
    input  logic [31:0]       dmem_rd_data
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [15:0]       load_cnt,
    output logic [15:0]       store_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [2:0]        cnt_q, cnt_d;

    logic              reqFire;
    logic              reqBad;
    logic              isStore;
    logic              inAccess;
    logic [31:0]       shifted;
    logic [31:0]       loadData;
    logic [3:0]        strb;
    logic [31:0]       wrData;

    // Only the low ADDR_W address bits are kept; the upper bits matter only for the range check at accept.
    assign reqFire  = (state_q == S_IDLE) && req_valid;
    assign reqBad   = (req_op[1:0] == 2'b11)
                   || ((req_op[1:0] == 2'b01) && req_addr[0])
                   || ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
                   || (|req_addr[31:ADDR_W]);
    assign isStore  = op_q[3];
    assign inAccess = (state_q == S_ACCESS);

    // Align the returned word to the addressed byte and sign/zero extend by op size.
    always_comb begin
        shifted  = dmem_rd_data >> {addr_q[1:0], 3'b000};
        loadData = shifted;
        case (op_q[1:0])
            2'b00:   loadData = {{24{~op_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   loadData = {{16{~op_q[2] & shifted[15]}}, shifted[15:0]};
            default: loadData = shifted;
        endcase
    end

    // Build byte-lane strobes and lane-replicated store data from the latched op.
    always_comb begin
        strb   = 4'b1111;
        wrData = wdata_q;
        case (op_q[1:0])
            2'b00: begin
                strb   = 4'b0001 << addr_q[1:0];
                wrData = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb   = 4'b0011 << addr_q[1:0];
                wrData = {2{wdata_q[15:0]}};
            end
            default: begin
                strb   = 4'b1111;
                wrData = wdata_q;
            end
        endcase
    end

    // Next-state logic for the sequencer, latency counter and response registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rdata_d = 32'h0;
                    err_d   = reqBad;
                    state_d = reqBad ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (isStore) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = 3'(MEM_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    rdata_d = loadData;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State, counter and response registers; op/addr/data are captured on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            op_q    <= 4'h0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (reqFire) begin
                op_q    <= req_op;
                addr_q  <= req_addr[ADDR_W-1:0];
                wdata_q <= req_wdata;
            end
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_rdata    = rsp_valid ? rdata_q : 32'h0;
    assign rsp_err      = rsp_valid & err_q;
    assign dmem_rd_en   = inAccess & ~isStore;
    assign dmem_wr_en   = inAccess & isStore;
    assign dmem_addr    = inAccess ? addr_q[ADDR_W-1:2] : '0;
    assign dmem_wr_strb = dmem_wr_en ? strb : 4'b0000;
    assign dmem_wr_data = dmem_wr_en ? wrData : 32'h0;

`ifdef LSU_PERF_CNT_EN
    // Saturating event counters: loads/stores on their access cycle, errors on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt  <= 16'h0;
            store_cnt <= 16'h0;
            err_cnt   <= 16'h0;
        end else begin
            if (dmem_rd_en && (load_cnt != 16'hFFFF)) begin
                load_cnt <= load_cnt + 16'h1;
            end
            if (dmem_wr_en && (store_cnt != 16'hFFFF)) begin
                store_cnt <= store_cnt + 16'h1;
            end
            if (reqFire && reqBad && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'h1;
            end
        end
    end
`endif

endmodule
